// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the architectural reset PC.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC = 32'h0000_0080;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Fetched-instruction buffer: power-of-two depth, push/pop/flush, occupancy count.
// Head data reads as zero while empty so the unreset storage never leaks out.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                    i_clk,
   input  logic                    i_resetn,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic                    i_flush,
   input  logic [WIDTH-1:0]        i_wdata,
   output logic [WIDTH-1:0]        o_rdata,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = i_push & ~i_flush;
   assign do_pop  = i_pop & ~i_flush & (o_count != '0);

   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
      end else if (i_flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (do_push && !do_pop) begin
            o_count <= o_count + CW'(1);
         end else if (!do_push && do_pop) begin
            o_count <= o_count - CW'(1);
         end
      end
   end

   assign o_rdata = (o_count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding a small
// buffer of {pc, instr} entries towards decode, with redirect flush.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              i_clk,
   input  logic              i_resetn,
   input  logic [ADDR_W-1:0] i_pc,
   output logic              o_pc_we,
   output logic              o_instr_req,
   output logic [ADDR_W-1:0] o_instr_addr,
   input  logic              i_instr_gnt,
   input  logic              i_instr_rvalid,
   input  logic [ADDR_W-1:0] i_instr_rdata,
   input  logic              i_flush,
   output logic              o_if_valid,
   input  logic              i_if_ready,
   output logic [ADDR_W-1:0] o_if_instr,
   output logic [ADDR_W-1:0] o_if_pc
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_M1 = CW'(FIFO_DEPTH - 1);

   fetch_state_e        state;
   fetch_state_e        state_nxt;
   logic [ADDR_W-1:0]   pend_pc;
   logic [CW-1:0]       count;
   logic                push;
   logic                pop;
   logic [2*ADDR_W-1:0] head;

   assign o_if_valid = (count != '0);
   assign pop        = o_if_valid & i_if_ready;
   assign o_if_pc    = head[2*ADDR_W-1:ADDR_W];
   assign o_if_instr = head[ADDR_W-1:0];

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         pend_pc <= '0;
      end else if (o_pc_we) begin
         pend_pc <= i_pc;
      end
   end

   always_comb begin
      state_nxt    = state;
      o_instr_req  = 1'b0;
      o_instr_addr = '0;
      o_pc_we      = 1'b0;
      push         = 1'b0;
      case (state)
         IDLE: begin
            if (!i_flush && (count < DEPTH_C)) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            o_instr_req  = 1'b1;
            o_instr_addr = {i_pc[ADDR_W-1:2], 2'b00};
            if (i_instr_gnt) begin
               o_pc_we   = ~i_flush;
               state_nxt = i_flush ? DISCARD : WAIT;
            end else if (i_flush) begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (i_flush) begin
               state_nxt = i_instr_rvalid ? IDLE : DISCARD;
            end else if (i_instr_rvalid) begin
               push = 1'b1;
               // a same-cycle pop frees the slot this push consumes
               state_nxt = (pop || (count < DEPTH_M1)) ? REQ : IDLE;
            end
         end
         DISCARD: begin
            if (i_instr_rvalid) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*ADDR_W)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_push   (push),
      .i_pop    (pop),
      .i_flush  (i_flush),
      .i_wdata  ({pend_pc, i_instr_rdata}),
      .o_rdata  (head),
      .o_count  (count)
   );

endmodule
